// File: rtl/tpu_pkg.sv
// Shared FP16 types, constants and arithmetic for the tiled dot-product unit.
// Arithmetic is round-to-nearest-even with subnormals flushed to zero.
package tpu_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_CANON_NAN = 16'h7E00;
  localparam fp16_t FP16_ZERO      = 16'h0000;
  localparam fp16_t FP16_ONE       = 16'h3C00;

  typedef enum logic {
    ACT_NONE,
    ACT_RELU
  } act_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_FINISH,
    S_OUT
  } state_e;

  function automatic fp16_t fp16_pack(
    input logic        s,
    input int          e,
    input logic [10:0] m,
    input logic        g,
    input logic        st
  );
    logic [11:0] r;
    int          ee;
    r  = {1'b0, m} + {11'd0, g & (st | m[0])};
    ee = e;
    if (r[11]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 31) return {s, 5'h1f, 10'h000};
    if (ee <= 0) return {s, 15'h0000};
    return {s, ee[4:0], r[9:0]};
  endfunction

  function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
    logic        s, an, bn, ai, bi, az, bz;
    logic [21:0] p;
    int          e;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    bn = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    ai = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
    bi = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
    az = (a[14:10] == 5'h00);
    bz = (b[14:10] == 5'h00);
    if (an | bn) return FP16_CANON_NAN;
    if (ai | bi) return (az | bz) ? FP16_CANON_NAN : {s, 5'h1f, 10'h000};
    if (az | bz) return {s, 15'h0000};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return fp16_pack(s, e + 1, p[21:11], p[10], |p[9:0]);
    return fp16_pack(s, e, p[20:10], p[9], |p[8:0]);
  endfunction

  function automatic fp16_t fp16_add(input fp16_t a, input fp16_t b);
    logic        an, bn, ai, bi, az, bz;
    fp16_t       x, y;
    logic [25:0] mx, my, lost, sum;
    int          d, p;
    an = (a[14:10] == 5'h1f) && (a[9:0] != 10'h0);
    bn = (b[14:10] == 5'h1f) && (b[9:0] != 10'h0);
    ai = (a[14:10] == 5'h1f) && (a[9:0] == 10'h0);
    bi = (b[14:10] == 5'h1f) && (b[9:0] == 10'h0);
    az = (a[14:10] == 5'h00);
    bz = (b[14:10] == 5'h00);
    if (an | bn) return FP16_CANON_NAN;
    if (ai & bi) return (a[15] != b[15]) ? FP16_CANON_NAN : a;
    if (ai) return a;
    if (bi) return b;
    if (az & bz) return {a[15] & b[15], 15'h0000};
    if (az) return b;
    if (bz) return a;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = int'(x[14:10]) - int'(y[14:10]);
    // hidden bit at [24], 14 guard/sticky bits below the mantissa
    mx = {2'b01, x[9:0], 14'h0};
    my = {2'b01, y[9:0], 14'h0};
    if (d > 25) begin
      my = 26'd1;
    end else begin
      lost = my & ((26'd1 << d) - 26'd1);
      my   = (my >> d) | {25'd0, |lost};
    end
    sum = (x[15] ^ y[15]) ? mx - my : mx + my;
    if (sum == 26'd0) return FP16_ZERO;
    p = 0;
    for (int i = 0; i < 26; i++) if (sum[i]) p = i;
    sum = sum << (25 - p);
    return fp16_pack(x[15], int'(x[14:10]) + p - 24,
                     sum[25:15], sum[14], |sum[13:0]);
  endfunction

  function automatic fp16_t fp16_act(input fp16_t x, input act_mode_e m);
    if ((m == ACT_RELU) && x[15]) return FP16_ZERO;
    return x;
  endfunction

endpackage

// File: rtl/fp16_adder_tree.sv
// Combinational balanced FP16 reduction; lanes 2k and 2k+1 pair first.
// Fixed pairing keeps results bit-deterministic.
module fp16_adder_tree
  import tpu_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  fp16_t [NUM_LANES-1:0] prod_i,
  output fp16_t                 sum_o
);

  always_comb begin : p_reduce
    fp16_t t [NUM_LANES];
    for (int k = 0; k < NUM_LANES; k++) t[k] = prod_i[k];
    for (int w = NUM_LANES / 2; w > 0; w = w / 2) begin
      for (int k = 0; k < w; k++) t[k] = fp16_add(t[2*k], t[2*k+1]);
    end
    sum_o = t[0];
  end

endmodule

// File: rtl/tiled_dot_product_unit.sv
// Tiled FP16 dot-product engine: lane multiply, tree reduce, accumulate,
// bias, optional ReLU, single result over valid/ready.
module tiled_dot_product_unit
  import tpu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_LANES = 4,
  parameter int MAX_TILES = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  bias,
  input  logic                              relu_en,
  output logic                              busy,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [NUM_LANES-1:0]              lane_mask,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]   a_in,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]   b_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic                              out_ovf,
  output logic [$clog2(MAX_TILES):0]        tile_count
);

  localparam int CW = $clog2(MAX_TILES) + 1;

  if (WIDTH != 16) begin : g_bad_width
    $error("tiled_dot_product_unit: WIDTH must be 16");
  end
  if ((NUM_LANES < 2) || ((NUM_LANES & (NUM_LANES - 1)) != 0)) begin : g_bad_lanes
    $error("tiled_dot_product_unit: NUM_LANES must be a power of 2 >= 2");
  end

  state_e                state_q, state_d;
  fp16_t [NUM_LANES-1:0] prod_q, prod_d;
  logic                  pv_q, pv_d;
  fp16_t                 acc_q, acc_d;
  fp16_t                 bias_q, bias_d;
  fp16_t                 out_q, out_d;
  act_mode_e             act_q, act_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  fp16_t                 tree_sum;
  logic                  tile_fire, start_fire;

  assign in_ready   = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign out_data   = out_q;
  assign out_ovf    = ovf_q;
  assign tile_count = cnt_q;
  assign tile_fire  = in_valid & in_ready;
  // back-to-back jobs: start may ride on the output handshake
  assign start_fire = start & ((state_q == S_IDLE) |
                               ((state_q == S_OUT) & out_ready));

  fp16_adder_tree #(
    .NUM_LANES(NUM_LANES)
  ) u_tree (
    .prod_i(prod_q),
    .sum_o (tree_sum)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_fire) state_d = S_ACCUM;
      S_ACCUM:  if (tile_fire & in_last) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_FINISH;
      S_FINISH: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) state_d = start_fire ? S_ACCUM : S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod_d = prod_q;
    pv_d   = tile_fire;
    acc_d  = acc_q;
    bias_d = bias_q;
    act_d  = act_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (tile_fire) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        prod_d[k] = lane_mask[k] ? fp16_mul(a_in[k], b_in[k]) : FP16_ZERO;
      end
      if (cnt_q == CW'(MAX_TILES)) ovf_d = 1'b1;
      else cnt_d = cnt_q + CW'(1);
    end
    if (pv_q) acc_d = fp16_add(acc_q, tree_sum);
    if (state_q == S_FINISH) out_d = fp16_act(fp16_add(acc_q, bias_q), act_q);
    if (start_fire) begin
      acc_d  = FP16_ZERO;
      bias_d = bias;
      act_d  = relu_en ? ACT_RELU : ACT_NONE;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      acc_q   <= FP16_ZERO;
      bias_q  <= FP16_ZERO;
      act_q   <= ACT_NONE;
      out_q   <= FP16_ZERO;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      act_q   <= act_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_tiled_dot_product_unit.sv
// Directed vector bench for tiled_dot_product_unit.
// Table of single-tile jobs plus hand sequences for multi-cycle cases.
module tb_tiled_dot_product_unit;

  localparam int CW = 7;
  localparam logic [15:0] P1   = 16'h3C00;
  localparam logic [15:0] N1   = 16'hBC00;
  localparam logic [15:0] P2   = 16'h4000;
  localparam logic [15:0] HALF = 16'h3800;
  localparam logic [15:0] INF  = 16'h7C00;
  localparam logic [15:0] NINF = 16'hFC00;
  localparam logic [15:0] Z    = 16'h0000;

  typedef struct {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0]       m;
    logic [15:0]      bias;
    logic             relu;
    logic [15:0]      exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      bias = '0;
  logic             relu_en = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic [3:0]       lane_mask = '0;
  logic [3:0][15:0] a_in = '0;
  logic [3:0][15:0] b_in = '0;
  logic             out_ready = 1'b0;
  logic             busy, in_ready, out_valid, out_ovf;
  logic [15:0]      out_data;
  logic [CW-1:0]    tile_count;

  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vt [16];

  tiled_dot_product_unit #(
    .WIDTH(16), .NUM_LANES(4), .MAX_TILES(64)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias),
    .relu_en(relu_en), .busy(busy), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .lane_mask(lane_mask),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_job(input logic [15:0] bs, input logic rl);
    start   = 1'b1;
    bias    = bs;
    relu_en = rl;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [3:0][15:0] a, input logic [3:0][15:0] b,
                      input logic [3:0] m, input logic last);
    int n;
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    lane_mask = m;
    in_last   = last;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("out_valid_wait", 32'(out_valid), 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_many(input int n, input logic [15:0] exp,
                          input logic exp_ovf);
    int lat;
    begin_job(Z, 1'b0);
    for (int k = 0; k < n; k++) send({4{P1}}, {4{P1}}, 4'hF, k == n - 1);
    wait_out(lat);
    chk($sformatf("many%0d_data", n), 32'(out_data), 32'(exp));
    chk($sformatf("many%0d_ovf", n), 32'(out_ovf), 32'(exp_ovf));
    chk($sformatf("many%0d_count", n), 32'(tile_count), 32'd64);
    take_out();
  endtask

  initial begin
    int  lat;
    logic seen;
    vt[0]  = '{{P1, P1, N1, P1}, {P2, P1, P1, P1}, 4'hF, HALF, 1'b0, 16'h4300};
    vt[1]  = '{{P1, P1, N1, P1}, {P2, P1, P1, P1}, 4'hF, HALF, 1'b1, 16'h4300};
    vt[2]  = '{{4{N1}}, {4{P1}}, 4'hF, HALF, 1'b1, 16'h0000};
    vt[3]  = '{{4{N1}}, {4{P1}}, 4'hF, HALF, 1'b0, 16'hC300};
    vt[4]  = '{{4{P1}}, {4{P1}}, 4'b0011, HALF, 1'b0, 16'h4100};
    vt[5]  = '{{4{P1}}, {4{P1}}, 4'b0000, HALF, 1'b0, 16'h3800};
    vt[6]  = '{{P1, P1, P1, INF}, {P1, P1, P1, Z}, 4'hF, HALF, 1'b0, 16'h7E00};
    vt[7]  = '{{P1, P1, P1, INF}, {4{P1}}, 4'hF, Z, 1'b0, 16'h7C00};
    vt[8]  = '{{P1, P1, NINF, INF}, {4{P1}}, 4'hF, Z, 1'b1, 16'h7E00};
    vt[9]  = '{{Z, Z, Z, 16'h3C01}, {Z, Z, Z, 16'h3C01}, 4'b0001, Z, 1'b0, 16'h3C02};
    vt[10] = '{{Z, Z, P1, 16'h6800}, {Z, Z, P1, P1}, 4'b0011, Z, 1'b0, 16'h6800};
    vt[11] = '{{Z, Z, Z, 16'h6801}, {Z, Z, Z, P1}, 4'b0001, P1, 1'b0, 16'h6802};
    vt[12] = '{{Z, Z, Z, 16'h0400}, {Z, Z, Z, HALF}, 4'b0001, HALF, 1'b0, 16'h3800};
    vt[13] = '{{Z, Z, Z, 16'h7BFF}, {Z, Z, Z, P2}, 4'b0001, Z, 1'b0, 16'h7C00};
    vt[14] = '{{P1, P1, P1, 16'h7E01}, {4{P1}}, 4'b1110, HALF, 1'b0, 16'h4300};
    vt[15] = '{{Z, Z, Z, 16'h0001}, {Z, Z, Z, 16'h7BFF}, 4'b0001, HALF, 1'b0, 16'h3800};

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_tile_count", 32'(tile_count), 32'd0);

    for (int i = 0; i < 16; i++) begin
      begin_job(vt[i].bias, vt[i].relu);
      send(vt[i].a, vt[i].b, vt[i].m, 1'b1);
      wait_out(lat);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vt[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_count", i), 32'(tile_count), 32'd1);
      take_out();
      chk($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    begin_job(HALF, 1'b0);
    send({P1, P1, N1, P1}, {P2, P1, P1, P1}, 4'hF, 1'b0);
    send({4{P2}}, {4{P1}}, 4'hF, 1'b1);
    wait_out(lat);
    chk("two_tile_data", 32'(out_data), 32'h49C0);
    chk("two_tile_count", 32'(tile_count), 32'd2);
    take_out();

    begin_job(HALF, 1'b0);
    send({P1, P1, N1, P1}, {P2, P1, P1, P1}, 4'hF, 1'b1);
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      start    = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'b1;
      tick();
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", c), 32'(out_data), 32'h4300);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_count", 32'(tile_count), 32'd1);
    take_out();
    chk("bp_idle", 32'(busy), 32'd0);

    begin_job(HALF, 1'b0);
    send({4{P1}}, {4{P1}}, 4'b0011, 1'b1);
    wait_out(lat);
    chk("b2b_first", 32'(out_data), 32'h4100);
    out_ready = 1'b1;
    start     = 1'b1;
    bias      = HALF;
    relu_en   = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    chk("b2b_out_valid", 32'(out_valid), 32'd0);
    chk("b2b_count_clr", 32'(tile_count), 32'd0);
    send({4{N1}}, {4{P1}}, 4'hF, 1'b1);
    wait_out(lat);
    chk("b2b_second", 32'(out_data), 32'h0000);
    take_out();

    run_many(64, 16'h5C00, 1'b0);
    run_many(65, 16'h5C10, 1'b1);
    begin_job(HALF, 1'b0);
    chk("ovf_clr", 32'(out_ovf), 32'd0);
    chk("count_clr", 32'(tile_count), 32'd0);
    send({4{P1}}, {4{P1}}, 4'b0000, 1'b1);
    wait_out(lat);
    chk("post_ovf_data", 32'(out_data), 32'h3800);
    take_out();

    begin_job(HALF, 1'b0);
    send({4{P1}}, {4{P1}}, 4'hF, 1'b0);
    send({4{P1}}, {4{P1}}, 4'hF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_count", 32'(tile_count), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("midrst_no_output", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
